// File: rtl/ldpc_encoder.sv
// Systematic LDPC encoder: forwards message beats, folds each into a
// quasi-cyclic syndrome s, prefix-XORs s into parity p, then emits p packed K lanes per beat.
// state | meaning
// IDLE  | waiting for en
// LOAD  | accepting message beats, forwarding them, updating s
// ACCUM | one cycle per parity bit: p[i] = p[i-1] ^ s[i]
// EMIT  | sending packed parity beats
module ldpc_encoder #(
  parameter int K          = 6,
  parameter int L          = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic         out_parity,
  output logic         out_last,
  output logic         busy
);

  localparam int NPB = (L + K - 1) / K;
  localparam int SW  = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, EMIT} state_t;

  state_t                state_q, state_d;
  logic [L-1:0]          s_q, s_d;
  logic [L-1:0]          p_q, p_d;
  logic                  acc_q, acc_d;
  logic                  acc_done_q, acc_done_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] em_q, em_d;
  logic                  out_valid_q, out_valid_d;
  logic [K-1:0]          out_data_q, out_data_d;
  logic                  out_parity_q, out_parity_d;
  logic                  out_last_q, out_last_d;

  logic                  out_free;
  logic                  out_take;
  logic                  accept;
  logic                  last_beat;
  logic                  accum_end;
  logic                  emit_last;
  int                    tgt;

  function automatic int lane_off(input int k);
    return (k * (k + 1)) % L;
  endfunction

  // Lanes past the end of p are padded with zeros.
  function automatic logic [K-1:0] parity_beat(input logic [L-1:0] pv, input int j);
    logic [K-1:0] b;
    int           n;
    b = '0;
    for (int i = 0; i < K; i++) begin
      n = j * K + i;
      if (n < L) b[i] = pv[SW'(n)];
    end
    return b;
  endfunction

  assign out_free  = !out_valid_q || out_ready;
  assign out_take  = out_valid_q && out_ready;
  assign accept    = (state_q == LOAD) && in_valid && out_free;
  assign last_beat = (beat_q == ADDR_WIDTH'(L - 1));
  assign accum_end = acc_done_q || (idx_q == ADDR_WIDTH'(L - 1));
  assign emit_last = (em_q == ADDR_WIDTH'(NPB - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    if (accept && last_beat) state_d = ACCUM;
      ACCUM:   if (accum_end && out_free) state_d = EMIT;
      EMIT:    if (out_take && emit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == LOAD) && out_free;
    busy       = (state_q != IDLE);
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    out_parity = out_parity_q;
    out_last   = out_last_q;
  end

  always_comb begin
    s_d          = s_q;
    p_d          = p_q;
    acc_d        = acc_q;
    acc_done_d   = acc_done_q;
    beat_d       = beat_q;
    idx_d        = idx_q;
    em_d         = em_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_last_d   = out_last_q;
    tgt          = 0;
    case (state_q)
      IDLE: begin
        if (en) begin
          s_d        = '0;
          p_d        = '0;
          acc_d      = 1'b0;
          acc_done_d = 1'b0;
          beat_d     = '0;
          idx_d      = '0;
          em_d       = '0;
        end
      end
      LOAD: begin
        if (out_take) out_valid_d = 1'b0;
        if (accept) begin
          out_valid_d  = 1'b1;
          out_data_d   = in_data;
          out_parity_d = 1'b0;
          out_last_d   = 1'b0;
          for (int k = 0; k < K; k++) begin
            tgt = int'(beat_q) + lane_off(k);
            if (tgt >= L) tgt = tgt - L;
            s_d[SW'(tgt)] = s_d[SW'(tgt)] ^ in_data[k];
          end
          if (last_beat) begin
            beat_d     = '0;
            idx_d      = '0;
            acc_d      = 1'b0;
            acc_done_d = 1'b0;
          end else begin
            beat_d = beat_q + ADDR_WIDTH'(1);
          end
        end
      end
      ACCUM: begin
        // The last systematic beat may still be waiting; accumulation runs regardless.
        if (out_take) out_valid_d = 1'b0;
        if (!acc_done_q) begin
          acc_d             = acc_q ^ s_q[SW'(idx_q)];
          p_d[SW'(idx_q)]   = acc_d;
          if (idx_q == ADDR_WIDTH'(L - 1)) acc_done_d = 1'b1;
          else                             idx_d      = idx_q + ADDR_WIDTH'(1);
        end
        if (accum_end && out_free) begin
          out_valid_d  = 1'b1;
          out_data_d   = parity_beat(p_d, 0);
          out_parity_d = 1'b1;
          out_last_d   = (NPB == 1);
          em_d         = '0;
          acc_done_d   = 1'b0;
          idx_d        = '0;
        end
      end
      EMIT: begin
        if (out_take) begin
          if (emit_last) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_parity_d = 1'b0;
            out_last_d   = 1'b0;
            em_d         = '0;
          end else begin
            em_d       = em_q + ADDR_WIDTH'(1);
            out_data_d = parity_beat(p_q, int'(em_q) + 1);
            out_last_d = (int'(em_q) + 1 == NPB - 1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q          <= '0;
      p_q          <= '0;
      acc_q        <= 1'b0;
      acc_done_q   <= 1'b0;
      beat_q       <= '0;
      idx_q        <= '0;
      em_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      s_q          <= s_d;
      p_q          <= p_d;
      acc_q        <= acc_d;
      acc_done_q   <= acc_done_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      em_q         <= em_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule
